axi_follower_resp_return: RTL and testbench

Parametrised response-return engine on the follower side of the AIB AXI bridge. Sits between the follower's AXI master B/R channels (`m_axi_b*`, `m_axi_r*`) and the AIB transmit path toward the leader. Buffers write responses and read beats in separate FIFOs, meters them with per-channel credits loaded from `init_b_credit`/`init_r_credit`, and arbitrates them onto one registered, tagged return stream. Generalises the fixed-width, unbuffered follower AXI port with configurable widths and depths, credit accounting and B/R arbitration.

---
 rtl/axi_follower_resp_return.sv | 234 +++++++++++++++++++++++
 tb/tb_axi_follower_resp_return.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_follower_resp_return.sv
// rtl/axi_follower_resp_return.sv - follower B/R response return engine with credits and arbitration
//
// Buffers AXI write responses (B) and read beats (R) in separate FIFOs, meters
// each channel with a credit counter and round-robins eligible heads onto one
// registered, tagged return stream toward the AIB transmit path.
//
// Ports:
//   clk_wr, rst_wr_n              clock, asynchronous active-low reset
//   init_b/r_credit, credit_load  credit load values and load strobe
//   b_credit_ret, r_credit_ret    +1 credit return pulses
//   m_axi_b*, m_axi_r*            AXI B and R channels (follower master side)
//   tx_valid/tx_ready, tx_*       return stream; tx_type 0 = B, 1 = R
//   b_credit_cnt, r_credit_cnt    live credit counters
//   credit_ovf                    sticky credit overflow flag
//
// Optional feature: define RESP_BURST_LOCK_EN to keep the grant on R from a
// granted rlast=0 beat until its rlast=1 beat has been issued.

module axi_follower_resp_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] head,
   output logic             full,
   output logic             empty
);
   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW:0]      count;

   assign full  = (count == (AW+1)'(DEPTH));
   assign empty = (count == '0);
   assign head  = mem[rd_ptr];

   // Storage is not reset; only the pointers define what is valid.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= push_data;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         if (push && !pop)      count <= count + (AW+1)'(1);
         else if (pop && !push) count <= count - (AW+1)'(1);
      end
   end
endmodule

module axi_follower_resp_credit #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load,
   input  logic [W-1:0] init,
   input  logic         ret,
   input  logic         take,
   output logic [W-1:0] cnt,
   output logic         sat
);
   localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

   logic [W-1:0] cnt_nxt;

   // A lone return at all-ones is dropped and reported; return plus take cancel.
   assign sat = !load && ret && !take && (cnt == '1);

   always_comb begin
      cnt_nxt = cnt;
      if (load)                  cnt_nxt = init;
      else if (ret && !take)     cnt_nxt = (cnt == '1) ? cnt : cnt + ONE;
      else if (take && !ret)     cnt_nxt = cnt - ONE;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cnt <= '0;
      else        cnt <= cnt_nxt;
   end
endmodule

module axi_follower_resp_return #(
   parameter int DWIDTH   = 128,
   parameter int IDWIDTH  = 4,
   parameter int BDEPTH   = 4,
   parameter int RDEPTH   = 8,
   parameter int CREDIT_W = 8
) (
   input  logic                clk_wr,
   input  logic                rst_wr_n,
   input  logic [CREDIT_W-1:0] init_b_credit,
   input  logic [CREDIT_W-1:0] init_r_credit,
   input  logic                credit_load,
   input  logic                b_credit_ret,
   input  logic                r_credit_ret,
   input  logic [IDWIDTH-1:0]  m_axi_bid,
   input  logic [1:0]          m_axi_bresp,
   input  logic                m_axi_bvalid,
   output logic                m_axi_bready,
   input  logic [IDWIDTH-1:0]  m_axi_rid,
   input  logic [DWIDTH-1:0]   m_axi_rdata,
   input  logic [1:0]          m_axi_rresp,
   input  logic                m_axi_rlast,
   input  logic                m_axi_rvalid,
   output logic                m_axi_rready,
   output logic                tx_valid,
   input  logic                tx_ready,
   output logic                tx_type,
   output logic [IDWIDTH-1:0]  tx_id,
   output logic [1:0]          tx_resp,
   output logic                tx_last,
   output logic [DWIDTH-1:0]   tx_data,
   output logic [CREDIT_W-1:0] b_credit_cnt,
   output logic [CREDIT_W-1:0] r_credit_cnt,
   output logic                credit_ovf
);
   localparam int BW = IDWIDTH + 2;
   localparam int RW = IDWIDTH + DWIDTH + 3;

   logic [BW-1:0] b_head;
   logic [RW-1:0] r_head;
   logic          b_full, b_empty, r_full, r_empty;
   logic          b_elig, r_elig, issue_ok;
   logic          grant_b, grant_r;
   logic          last_grant_r;
   logic          lock_active;
   logic          b_sat, r_sat;

   assign m_axi_bready = !b_full;
   assign m_axi_rready = !r_full;

   axi_follower_resp_fifo #(.WIDTH(BW), .DEPTH(BDEPTH)) u_b_fifo (
      .clk(clk_wr), .rst_n(rst_wr_n),
      .push(m_axi_bvalid && !b_full), .push_data({m_axi_bid, m_axi_bresp}),
      .pop(grant_b), .head(b_head), .full(b_full), .empty(b_empty)
   );

   axi_follower_resp_fifo #(.WIDTH(RW), .DEPTH(RDEPTH)) u_r_fifo (
      .clk(clk_wr), .rst_n(rst_wr_n),
      .push(m_axi_rvalid && !r_full),
      .push_data({m_axi_rid, m_axi_rdata, m_axi_rresp, m_axi_rlast}),
      .pop(grant_r), .head(r_head), .full(r_full), .empty(r_empty)
   );

   axi_follower_resp_credit #(.W(CREDIT_W)) u_b_credit (
      .clk(clk_wr), .rst_n(rst_wr_n), .load(credit_load), .init(init_b_credit),
      .ret(b_credit_ret), .take(grant_b), .cnt(b_credit_cnt), .sat(b_sat)
   );

   axi_follower_resp_credit #(.W(CREDIT_W)) u_r_credit (
      .clk(clk_wr), .rst_n(rst_wr_n), .load(credit_load), .init(init_r_credit),
      .ret(r_credit_ret), .take(grant_r), .cnt(r_credit_cnt), .sat(r_sat)
   );

   assign b_elig   = !b_empty && (b_credit_cnt != '0);
   assign r_elig   = !r_empty && (r_credit_cnt != '0);
   assign issue_ok = (!tx_valid || tx_ready) && !credit_load;

`ifdef RESP_BURST_LOCK_EN
   logic r_lock;

   // Lock follows the last granted R beat: open burst sets it, rlast clears it.
   always_ff @(posedge clk_wr or negedge rst_wr_n) begin
      if (!rst_wr_n)    r_lock <= 1'b0;
      else if (grant_r) r_lock <= !r_head[0];
   end
   assign lock_active = r_lock;
`else
   assign lock_active = 1'b0;
`endif

   // Round-robin: on a tie the channel not granted last time wins.
   always_comb begin
      grant_b = 1'b0;
      grant_r = 1'b0;
      if (issue_ok) begin
         if (lock_active) begin
            grant_r = r_elig;
         end else if (b_elig && r_elig) begin
            grant_b = last_grant_r;
            grant_r = !last_grant_r;
         end else begin
            grant_b = b_elig;
            grant_r = r_elig;
         end
      end
   end

   always_ff @(posedge clk_wr or negedge rst_wr_n) begin
      if (!rst_wr_n) begin
         tx_valid     <= 1'b0;
         tx_type      <= 1'b0;
         tx_id        <= '0;
         tx_resp      <= '0;
         tx_last      <= 1'b0;
         tx_data      <= '0;
         last_grant_r <= 1'b1;
         credit_ovf   <= 1'b0;
      end else begin
         credit_ovf <= credit_ovf | b_sat | r_sat;
         if (grant_b) begin
            tx_valid     <= 1'b1;
            tx_type      <= 1'b0;
            tx_id        <= b_head[BW-1:2];
            tx_resp      <= b_head[1:0];
            tx_last      <= 1'b1;
            tx_data      <= '0;
            last_grant_r <= 1'b0;
         end else if (grant_r) begin
            tx_valid     <= 1'b1;
            tx_type      <= 1'b1;
            tx_id        <= r_head[RW-1 -: IDWIDTH];
            tx_data      <= r_head[DWIDTH+2:3];
            tx_resp      <= r_head[2:1];
            tx_last      <= r_head[0];
            last_grant_r <= 1'b1;
         end else if (tx_ready) begin
            tx_valid <= 1'b0;
         end
      end
   end
endmodule

// File: tb/tb_axi_follower_resp_return.sv
// tb/tb_axi_follower_resp_return.sv - scoreboard bench for axi_follower_resp_return
module tb_axi_follower_resp_return;
   localparam int DW = 128;
   localparam int IW = 4;
   localparam int CW = 8;

   typedef struct packed {
      logic          typ;
      logic [IW-1:0] id;
      logic [1:0]    resp;
      logic          last;
      logic [DW-1:0] data;
   } beat_t;

   logic          clk_wr = 1'b0;
   logic          rst_wr_n = 1'b0;
   logic [CW-1:0] init_b_credit = '0, init_r_credit = '0;
   logic          credit_load = 1'b0, b_credit_ret = 1'b0, r_credit_ret = 1'b0;
   logic [IW-1:0] m_axi_bid = '0, m_axi_rid = '0;
   logic [1:0]    m_axi_bresp = '0, m_axi_rresp = '0;
   logic          m_axi_bvalid = 1'b0, m_axi_rvalid = 1'b0, m_axi_rlast = 1'b0;
   logic [DW-1:0] m_axi_rdata = '0;
   logic          m_axi_bready, m_axi_rready;
   logic          tx_valid, tx_type, tx_last;
   logic          tx_ready = 1'b0;
   logic [IW-1:0] tx_id;
   logic [1:0]    tx_resp;
   logic [DW-1:0] tx_data;
   logic [CW-1:0] b_credit_cnt, r_credit_cnt;
   logic          credit_ovf;

   beat_t exp_q[$];
   beat_t mon_act, mon_exp;
   int    total = 0;
   int    bad = 0;
   int    n_tx = 0;
   int    base;

   axi_follower_resp_return dut (
      .clk_wr(clk_wr), .rst_wr_n(rst_wr_n),
      .init_b_credit(init_b_credit), .init_r_credit(init_r_credit),
      .credit_load(credit_load), .b_credit_ret(b_credit_ret), .r_credit_ret(r_credit_ret),
      .m_axi_bid(m_axi_bid), .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid),
      .m_axi_bready(m_axi_bready),
      .m_axi_rid(m_axi_rid), .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
      .m_axi_rlast(m_axi_rlast), .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready),
      .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_type(tx_type), .tx_id(tx_id),
      .tx_resp(tx_resp), .tx_last(tx_last), .tx_data(tx_data),
      .b_credit_cnt(b_credit_cnt), .r_credit_cnt(r_credit_cnt), .credit_ovf(credit_ovf)
   );

   initial forever #5 clk_wr = ~clk_wr;

   initial begin
      #200000;
      $display("FAIL watchdog act=running req=finished");
      $fatal(1, "bench timeout");
   end

   function automatic logic [DW-1:0] rdat(input int i);
      logic [31:0] w;
      w = 32'hA5A5_0000 + 32'(i);
      return {w, ~w, w ^ 32'h0F0F_0F0F, 32'(i)};
   endfunction

   function automatic beat_t mk_b(input logic [IW-1:0] id, input logic [1:0] resp);
      return {1'b0, id, resp, 1'b1, {DW{1'b0}}};
   endfunction

   function automatic beat_t mk_r(input logic [IW-1:0] id, input logic [1:0] resp,
                                  input logic last, input logic [DW-1:0] data);
      return {1'b1, id, resp, last, data};
   endfunction

   task automatic check(input string name, input logic [135:0] act, input logic [135:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s act=%h req=%h", name, act, req);
      end
   endtask

   // Scoreboard monitor: a beat seen valid&ready at the negedge transfers on the next posedge.
   always @(negedge clk_wr) begin
      if (rst_wr_n && tx_valid && tx_ready) begin
         n_tx++;
         mon_act = {tx_type, tx_id, tx_resp, tx_last, tx_data};
         if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL tx_unexpected act=%h req=none", mon_act);
         end else begin
            mon_exp = exp_q.pop_front();
            check("tx_beat", mon_act, mon_exp);
         end
      end
   end

   task automatic tick;
      @(posedge clk_wr);
      #1;
   endtask

   task automatic push_b(input logic [IW-1:0] id, input logic [1:0] resp);
      int n = 0;
      m_axi_bid = id; m_axi_bresp = resp; m_axi_bvalid = 1'b1;
      @(negedge clk_wr);
      while (!m_axi_bready && n < 50) begin n++; @(negedge clk_wr); end
      check("b_push_ready", 136'(m_axi_bready), 136'(1));
      tick;
      m_axi_bvalid = 1'b0;
   endtask

   task automatic push_r(input logic [IW-1:0] id, input logic [1:0] resp,
                         input logic last, input logic [DW-1:0] data);
      int n = 0;
      m_axi_rid = id; m_axi_rresp = resp; m_axi_rlast = last; m_axi_rdata = data;
      m_axi_rvalid = 1'b1;
      @(negedge clk_wr);
      while (!m_axi_rready && n < 50) begin n++; @(negedge clk_wr); end
      check("r_push_ready", 136'(m_axi_rready), 136'(1));
      tick;
      m_axi_rvalid = 1'b0;
   endtask

   task automatic load_credits(input logic [CW-1:0] b, input logic [CW-1:0] r);
      init_b_credit = b; init_r_credit = r; credit_load = 1'b1;
      tick;
      credit_load = 1'b0;
   endtask

   task automatic wait_drain(input int max_cyc);
      int k = 0;
      while (exp_q.size() != 0 && k < max_cyc) begin @(negedge clk_wr); k++; end
      check("drain_left", 136'(exp_q.size()), 136'(0));
      tick;
   endtask

   initial begin
      // Reset values
      repeat (3) @(posedge clk_wr);
      @(negedge clk_wr);
      check("rst_tx_valid", 136'(tx_valid), 136'(0));
      check("rst_payload", {tx_type, tx_id, tx_resp, tx_last, tx_data}, 136'(0));
      check("rst_credits", 136'({b_credit_cnt, r_credit_cnt}), 136'(0));
      check("rst_ovf", 136'(credit_ovf), 136'(0));
      check("rst_readies", 136'({m_axi_bready, m_axi_rready}), 136'(3));
      tick;
      rst_wr_n = 1'b1;

      // B credit limit: 2 credits, 3 responses
      tx_ready = 1'b1;
      load_credits(8'd2, 8'd4);
      @(negedge clk_wr);
      check("load_b", 136'(b_credit_cnt), 136'(2));
      check("load_r", 136'(r_credit_cnt), 136'(4));
      tick;
      base = n_tx;
      exp_q.push_back(mk_b(4'h1, 2'd0));
      exp_q.push_back(mk_b(4'h2, 2'd1));
      exp_q.push_back(mk_b(4'h3, 2'd2));
      push_b(4'h1, 2'd0);
      push_b(4'h2, 2'd1);
      push_b(4'h3, 2'd2);
      repeat (5) @(negedge clk_wr);
      check("b_issued_two", 136'(n_tx - base), 136'(2));
      check("b_credit_zero", 136'(b_credit_cnt), 136'(0));
      check("b_third_waits", 136'(tx_valid), 136'(0));
      tick;
      b_credit_ret = 1'b1;
      tick;
      b_credit_ret = 1'b0;
      @(negedge clk_wr);
      check("ret_not_yet", 136'(tx_valid), 136'(0));
      @(negedge clk_wr);
      check("ret_issue", 136'(tx_valid), 136'(1));
      check("ret_b_cnt", 136'(b_credit_cnt), 136'(0));
      tick;
      wait_drain(20);

      // Fill R FIFO behind a stalled output register
      tx_ready = 1'b0;
      load_credits(8'd8, 8'd16);
      for (int i = 0; i < 9; i++) exp_q.push_back(mk_r(4'(i), 2'(i % 4), 1'b1, rdat(i)));
      for (int i = 0; i < 9; i++) push_r(4'(i), 2'(i % 4), 1'b1, rdat(i));
      for (int k = 0; k < 3; k++) begin
         @(negedge clk_wr);
         check("r_full_ready", 136'(m_axi_rready), 136'(0));
         check("stall_valid", 136'(tx_valid), 136'(1));
         check("stall_payload", {tx_type, tx_id, tx_resp, tx_last, tx_data},
               mk_r(4'd0, 2'd0, 1'b1, rdat(0)));
      end
      tick;
      tx_ready = 1'b1;
      wait_drain(40);
      check("r_cnt_after_fill", 136'(r_credit_cnt), 136'(7));

      // B/R alternation
      tx_ready = 1'b0;
      exp_q.push_back(mk_b(4'hA, 2'd0));
      exp_q.push_back(mk_r(4'h1, 2'd1, 1'b1, rdat(11)));
      exp_q.push_back(mk_b(4'hB, 2'd1));
      exp_q.push_back(mk_r(4'h2, 2'd2, 1'b1, rdat(12)));
      exp_q.push_back(mk_b(4'hC, 2'd2));
      exp_q.push_back(mk_r(4'h3, 2'd3, 1'b1, rdat(13)));
      push_b(4'hA, 2'd0);
      push_b(4'hB, 2'd1);
      push_b(4'hC, 2'd2);
      push_r(4'h1, 2'd1, 1'b1, rdat(11));
      push_r(4'h2, 2'd2, 1'b1, rdat(12));
      push_r(4'h3, 2'd3, 1'b1, rdat(13));
      tx_ready = 1'b1;
      wait_drain(30);
      check("alt_b_cnt", 136'(b_credit_cnt), 136'(5));
      check("alt_r_cnt", 136'(r_credit_cnt), 136'(4));

`ifdef RESP_BURST_LOCK_EN
      // Burst lock: 4-beat R burst stays contiguous ahead of a pending B
      tx_ready = 1'b0;
      for (int i = 0; i < 4; i++) exp_q.push_back(mk_r(4'(4 + i), 2'd0, 1'(i == 3), rdat(20 + i)));
      exp_q.push_back(mk_b(4'hD, 2'd3));
      push_r(4'h4, 2'd0, 1'b0, rdat(20));
      push_b(4'hD, 2'd3);
      for (int i = 1; i < 4; i++) push_r(4'(4 + i), 2'd0, 1'(i == 3), rdat(20 + i));
      tx_ready = 1'b1;
      wait_drain(30);
`endif

      // Saturation and simultaneous return/consume
      tx_ready = 1'b1;
      load_credits(8'd5, 8'd255);
      r_credit_ret = 1'b1;
      tick;
      r_credit_ret = 1'b0;
      @(negedge clk_wr);
      check("sat_r_cnt", 136'(r_credit_cnt), 136'(255));
      check("sat_ovf", 136'(credit_ovf), 136'(1));
      tick;
      exp_q.push_back(mk_b(4'h5, 2'd3));
      push_b(4'h5, 2'd3);
      b_credit_ret = 1'b1;
      tick;
      b_credit_ret = 1'b0;
      @(negedge clk_wr);
      check("ret_and_use_b", 136'(b_credit_cnt), 136'(5));
      tick;
      wait_drain(20);

      // credit_load mid-stream
      tx_ready = 1'b0;
      for (int i = 8; i < 11; i++) exp_q.push_back(mk_r(4'(i), 2'd1, 1'b1, rdat(30 + i)));
      for (int i = 8; i < 11; i++) push_r(4'(i), 2'd1, 1'b1, rdat(30 + i));
      init_b_credit = 8'd3; init_r_credit = 8'd6; credit_load = 1'b1; tx_ready = 1'b1;
      tick;
      credit_load = 1'b0;
      @(negedge clk_wr);
      check("load_no_issue", 136'(tx_valid), 136'(0));
      check("load_counts", 136'({b_credit_cnt, r_credit_cnt}), 136'({8'd3, 8'd6}));
      @(negedge clk_wr);
      check("load_resume", 136'(tx_valid), 136'(1));
      tick;
      wait_drain(20);
      check("load_r_after", 136'(r_credit_cnt), 136'(4));
      check("ovf_sticky", 136'(credit_ovf), 136'(1));

      // Reset mid-burst
      tx_ready = 1'b0;
      push_r(4'hE, 2'd0, 1'b0, rdat(50));
      push_r(4'hF, 2'd0, 1'b1, rdat(51));
      rst_wr_n = 1'b0;
      #2;
      check("arst_tx_valid", 136'(tx_valid), 136'(0));
      check("arst_payload", {tx_type, tx_id, tx_resp, tx_last, tx_data}, 136'(0));
      check("arst_credits", 136'({b_credit_cnt, r_credit_cnt}), 136'(0));
      check("arst_ovf", 136'(credit_ovf), 136'(0));
      check("arst_readies", 136'({m_axi_bready, m_axi_rready}), 136'(3));
      exp_q.delete();
      tick;
      rst_wr_n = 1'b1;
      tx_ready = 1'b1;
      load_credits(8'd2, 8'd2);
      exp_q.push_back(mk_b(4'h9, 2'd1));
      push_b(4'h9, 2'd1);
      wait_drain(20);
      repeat (4) @(negedge clk_wr);
      check("post_rst_idle", 136'(tx_valid), 136'(0));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
